// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch front end with an in-order instruction buffer.
//
// Issues word-aligned fetch requests from fetch_pc, remembers the PC of every
// request still in flight, and pairs each in-order memory response with its PC
// before placing it in a small FIFO read by decode. A redirect empties the
// buffer and moves fetch_pc; responses to requests issued before the redirect
// are counted off and discarded while in FLUSH.
//
// Ports
//   clk, reset            clock and asynchronous active-low reset
//   redirect_valid/_pc    branch/exception redirect (pc is forced word-aligned)
//   imem_req_*            fetch request (valid/ready handshake, address)
//   imem_rsp_*            in-order instruction return, no backpressure
//   inst_*                head of the instruction buffer to decode (valid/ready)
module fetch_unit #(
  parameter int dataWidth = 64,
  parameter int instWidth = 32,
  parameter int depth     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 redirect_valid,
  input  logic [dataWidth-1:0] redirect_pc,
  output logic                 imem_req_valid,
  output logic [dataWidth-1:0] imem_req_addr,
  input  logic                 imem_req_ready,
  input  logic                 imem_rsp_valid,
  input  logic [instWidth-1:0] imem_rsp_data,
  output logic                 inst_valid,
  output logic [instWidth-1:0] inst_data,
  output logic [dataWidth-1:0] inst_pc,
  input  logic                 inst_ready
);

  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DepthLim = (CW+1)'(depth);

  typedef enum logic {FETCH, FLUSH} state_e;

  state_e               state_q, state_d;
  logic [dataWidth-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]        out_cnt_q, out_cnt_d;
  logic [CW-1:0]        buf_cnt_q, buf_cnt_d;
  logic [CW-1:0]        drop_cnt_q, drop_cnt_d;
  logic [AW-1:0]        out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [AW-1:0]        buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;

  logic [dataWidth-1:0] out_pc_mem   [depth];
  logic [instWidth-1:0] buf_data_mem [depth];
  logic [dataWidth-1:0] buf_pc_mem   [depth];

  logic [CW:0]   occupancy;
  logic [CW-1:0] pending;
  logic          accept, rsp_hit, push, pop;

  // The low address bits are discarded when the redirect target is aligned.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign imem_req_addr = fetch_pc_q;
  assign inst_valid    = (buf_cnt_q != '0);
  assign inst_data     = buf_data_mem[buf_rd_q];
  assign inst_pc       = buf_pc_mem[buf_rd_q];

  always_comb begin
    occupancy = {1'b0, buf_cnt_q} + {1'b0, out_cnt_q};
    // Reserving a buffer slot per in-flight request means a response can
    // always be pushed; reset gating keeps the request quiet while held.
    imem_req_valid = reset && (state_q == FETCH) && (occupancy < DepthLim);
    accept  = imem_req_valid && imem_req_ready;
    // Responses still owed: tracked per PC in FETCH, only counted in FLUSH.
    pending = (state_q == FETCH) ? out_cnt_q : drop_cnt_q;
    // A response with nothing owed is a protocol error and is ignored.
    rsp_hit = imem_rsp_valid && (pending != '0);
    push    = rsp_hit && (state_q == FETCH) && !redirect_valid;
    pop     = inst_valid && inst_ready;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    out_cnt_d  = out_cnt_q;
    buf_cnt_d  = buf_cnt_q;
    drop_cnt_d = drop_cnt_q;
    out_wr_d   = out_wr_q;
    out_rd_d   = out_rd_q;
    buf_wr_d   = buf_wr_q;
    buf_rd_d   = buf_rd_q;

    if (accept) begin
      fetch_pc_d = fetch_pc_q + dataWidth'(4);
      out_wr_d   = out_wr_q + AW'(1);
    end

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[dataWidth-1:2], 2'b00};
      // Everything in flight after this edge belongs to the old path.
      drop_cnt_d = pending + CW'(accept) - CW'(rsp_hit);
      out_cnt_d  = '0;
      out_wr_d   = '0;
      out_rd_d   = '0;
      buf_cnt_d  = '0;
      buf_wr_d   = '0;
      buf_rd_d   = '0;
      state_d    = (drop_cnt_d != '0) ? FLUSH : FETCH;
    end else if (state_q == FETCH) begin
      out_cnt_d = out_cnt_q + CW'(accept) - CW'(rsp_hit);
      if (rsp_hit) out_rd_d = out_rd_q + AW'(1);
      if (push)    buf_wr_d = buf_wr_q + AW'(1);
      if (pop)     buf_rd_d = buf_rd_q + AW'(1);
      buf_cnt_d = buf_cnt_q + CW'(push) - CW'(pop);
    end else begin
      drop_cnt_d = drop_cnt_q - CW'(rsp_hit);
      if (drop_cnt_d == '0) state_d = FETCH;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples its _d value from before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FETCH;
      fetch_pc_q <= '0;
      out_cnt_q  <= '0;
      buf_cnt_q  <= '0;
      drop_cnt_q <= '0;
      out_wr_q   <= '0;
      out_rd_q   <= '0;
      buf_wr_q   <= '0;
      buf_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_cnt_q  <= out_cnt_d;
      buf_cnt_q  <= buf_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      out_wr_q   <= out_wr_d;
      out_rd_q   <= out_rd_d;
      buf_wr_q   <= buf_wr_d;
      buf_rd_q   <= buf_rd_d;
    end
  end

  // NOTE: storage arrays are not reset; the counters decide which entries
  // are meaningful, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (accept) out_pc_mem[out_wr_q] <= fetch_pc_q;
    if (push) begin
      buf_data_mem[buf_wr_q] <= imem_rsp_data;
      buf_pc_mem[buf_wr_q]   <= out_pc_mem[out_rd_q];
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: streaming, backpressure, redirect/flush,
// address wrap, spurious response and asynchronous reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;
  logic        inst_ready;

  logic auto_rsp;
  int   n_checks = 0;
  int   n_errors = 0;

  fetch_unit #(.dataWidth(64), .instWidth(32), .depth(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock; the memory model answers each accepted request one cycle later.
  task automatic tick();
    logic        acc;
    logic [63:0] a;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    @(posedge clk);
    #1;
    if (auto_rsp) begin
      imem_rsp_valid = acc;
      imem_rsp_data  = acc ? mem_word(a) : 32'h0;
    end
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    inst_ready     = 1'b0;
    auto_rsp       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_inst_valid", inst_valid, 0);
    reset = 1'b1;
    #1;
    check("rst_addr", imem_req_addr, 0);
  endtask

  initial begin
    int n_acc;

    // Streaming fetch with decode always ready.
    do_reset();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    auto_rsp       = 1'b1;
    check("s_req_valid", imem_req_valid, 1);
    tick();
    check("s_addr1", imem_req_addr, 64'h4);
    tick();
    for (int k = 0; k < 6; k++) begin
      check("s_inst_valid", inst_valid, 1);
      check("s_inst_pc", inst_pc, 64'(k * 4));
      check("s_inst_data", inst_data, mem_word(64'(k * 4)));
      check("s_addr", imem_req_addr, 64'((k + 2) * 4));
      tick();
    end

    // Decode stalled: buffer fills with four, then fetch resumes at 0x10.
    do_reset();
    imem_req_ready = 1'b1;
    auto_rsp       = 1'b1;
    n_acc          = 0;
    for (int k = 0; k < 8; k++) begin
      if (imem_req_valid && imem_req_ready) n_acc++;
      tick();
    end
    check("bp_accepts", 64'(n_acc), 4);
    check("bp_req_valid", imem_req_valid, 0);
    check("bp_inst_valid", inst_valid, 1);
    check("bp_inst_pc", inst_pc, 64'h0);
    check("bp_inst_data", inst_data, mem_word(64'h0));
    check("bp_addr", imem_req_addr, 64'h10);
    inst_ready = 1'b1;
    tick();
    check("bp_resume_pc", inst_pc, 64'h4);
    check("bp_resume_req", imem_req_valid, 1);
    check("bp_resume_addr", imem_req_addr, 64'h10);
    tick();
    check("bp_next_pc", inst_pc, 64'h8);
    check("bp_next_addr", imem_req_addr, 64'h14);

    // Redirect with two requests outstanding.
    do_reset();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    tick();
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h1003;
    tick();
    redirect_valid = 1'b0;
    check("fl_req_valid", imem_req_valid, 0);
    check("fl_inst_valid", inst_valid, 0);
    check("fl_addr", imem_req_addr, 64'h1000);
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_0001;
    tick();
    check("fl_drop1_req", imem_req_valid, 0);
    check("fl_drop1_inst", inst_valid, 0);
    tick();
    imem_rsp_valid = 1'b0;
    check("fl_done_req", imem_req_valid, 1);
    check("fl_done_addr", imem_req_addr, 64'h1000);
    check("fl_done_inst", inst_valid, 0);
    auto_rsp = 1'b1;
    tick();
    check("fl_addr2", imem_req_addr, 64'h1004);
    tick();
    check("fl_first_valid", inst_valid, 1);
    check("fl_first_pc", inst_pc, 64'h1000);
    check("fl_first_data", inst_data, mem_word(64'h1000));

    // Redirect coinciding with an accepted request, a pop and a response.
    do_reset();
    imem_req_ready = 1'b1;
    auto_rsp       = 1'b1;
    tick();
    tick();
    check("rc_head_valid", inst_valid, 1);
    check("rc_head_pc", inst_pc, 64'h0);
    check("rc_rsp_pending", imem_rsp_valid, 1);
    check("rc_req_now", imem_req_valid, 1);
    auto_rsp       = 1'b0;
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2000;
    tick();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    check("rc_inst_valid", inst_valid, 0);
    check("rc_req_valid", imem_req_valid, 0);
    check("rc_addr", imem_req_addr, 64'h2000);
    tick();
    check("rc_still_flush", imem_req_valid, 0);
    imem_rsp_valid = 1'b1;
    tick();
    imem_rsp_valid = 1'b0;
    check("rc_fetch_req", imem_req_valid, 1);
    check("rc_no_stale", inst_valid, 0);
    check("rc_fetch_addr", imem_req_addr, 64'h2000);
    auto_rsp = 1'b1;
    tick();
    tick();
    check("rc_first_pc", inst_pc, 64'h2000);
    check("rc_first_data", inst_data, mem_word(64'h2000));

    // Spurious response is ignored, then the address wraps past all-ones.
    do_reset();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_BAD0;
    tick();
    imem_rsp_valid = 1'b0;
    check("sp_inst_valid", inst_valid, 0);
    auto_rsp       = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    check("wr_fetch_req", imem_req_valid, 1);
    check("wr_addr_top", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    imem_req_ready = 1'b1;
    tick();
    check("wr_addr_zero", imem_req_addr, 64'h0);
    tick();
    check("wr_inst_valid", inst_valid, 1);
    check("wr_inst_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wr_inst_data", inst_data, 32'hC0DE_FFFC);

    // Asynchronous reset in the middle of activity.
    do_reset();
    imem_req_ready = 1'b1;
    auto_rsp       = 1'b1;
    repeat (3) tick();
    check("ar_pre_valid", inst_valid, 1);
    #2;
    reset          = 1'b0;
    auto_rsp       = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    check("ar_inst_valid", inst_valid, 0);
    check("ar_req_valid", imem_req_valid, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("ar_rel_req", imem_req_valid, 1);
    check("ar_rel_addr", imem_req_addr, 64'h0);
    check("ar_rel_inst", inst_valid, 0);
    tick();
    check("ar_addr4", imem_req_addr, 64'h4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
